// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg -- shared definitions for the I2S record-path receiver.
//   state_t          : word-tracking FSM state (IDLE / LEFT / RIGHT)
//   DATA_WIDTH_DEF   : default captured sample width per channel
//   SYNC_STAGES_DEF  : default synchroniser depth on the codec inputs
// -----------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF  = 24;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/i2s_sync.sv
// -----------------------------------------------------------------------------
// i2s_sync -- multi-flop synchroniser for one asynchronous codec input.
// Ports:
//   CLK   : block clock
//   RESET : asynchronous active-high reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output (STAGES CLK cycles of latency)
// -----------------------------------------------------------------------------
module i2s_sync
  import i2s_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx -- I2S record-path receiver with a valid/ready sample-pair output.
// Optional feature: define I2S_RX_PEAK_METER_EN to build the absolute-peak
// meters; without it peak_l/peak_r are tied to 0 and peak_clr is ignored.
// Ports:
//   CLK, RESET                 : block clock, asynchronous active-high reset
//   AC_BCLK/AC_RECLRC/AC_RECDAT: codec bit clock, word select (0=L), data
//   sample_l/sample_r          : committed stereo pair
//   sample_valid/sample_ready  : pair handshake
//   overflow/overflow_clr      : sticky dropped-pair flag and its clear
//   peak_l/peak_r/peak_clr     : absolute peak meters and their clear
// -----------------------------------------------------------------------------
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AC_BCLK,
  input  logic                  AC_RECLRC,
  input  logic                  AC_RECDAT,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [DATA_WIDTH-2:0] peak_l,
  output logic [DATA_WIDTH-2:0] peak_r,
  input  logic                  peak_clr
);

  localparam int             CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]  DW_C = CW'(DATA_WIDTH);

  // Left-justify a word of n received bits, zero-filling the missing LSBs.
  function automatic logic [DATA_WIDTH-1:0] msb_align(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [CW-1:0]         n);
    return w << (DW_C - n);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: synchronisers and BCLK edge / word-boundary detection
  // ---------------------------------------------------------------------------
  logic bclk_s, lrc_s, dat_s;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .CLK(CLK), .RESET(RESET), .d_i(AC_BCLK),   .q_o(bclk_s)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrc (
    .CLK(CLK), .RESET(RESET), .d_i(AC_RECLRC), .q_o(lrc_s)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .CLK(CLK), .RESET(RESET), .d_i(AC_RECDAT), .q_o(dat_s)
  );

  logic bclk_prev_q, lrc_prev_q;
  logic rise, boundary;

  assign rise     = bclk_s & ~bclk_prev_q;
  assign boundary = lrc_s ^ lrc_prev_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bclk_prev_q <= 1'b0;
      lrc_prev_q  <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
      if (rise) lrc_prev_q <= lrc_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: word FSM, bit counter, shift register, left hold
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-2:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] word_full, word_aligned;
  logic                  word_done;
  logic                  pair_vld_p1_q, pair_vld_p1_d;
  logic [DATA_WIDTH-1:0] pair_l_p1_q, pair_l_p1_d;
  logic [DATA_WIDTH-1:0] pair_r_p1_q, pair_r_p1_d;

  assign cnt_inc      = cnt_q + 1'b1;
  assign word_full    = {sr_q, dat_s};
  assign word_aligned = msb_align(word_full, cnt_inc);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    hold_l_d      = hold_l_q;
    pair_vld_p1_d = 1'b0;
    pair_l_p1_d   = pair_l_p1_q;
    pair_r_p1_d   = pair_r_p1_q;
    word_done     = 1'b0;
    if (rise) begin
      // The bit on a boundary rise is still the previous word's LSB, so it is
      // shifted in before the counter restarts. Once DATA_WIDTH bits are in,
      // further bits of a long word are dropped.
      if ((state_q != ST_IDLE) && (cnt_q < DW_C)) begin
        sr_d      = word_full[DATA_WIDTH-2:0];
        cnt_d     = cnt_inc;
        word_done = (cnt_inc == DW_C) || boundary;
      end
      if (boundary) begin
        cnt_d = '0;
        sr_d  = '0;
        case (state_q)
          ST_IDLE:  if (!lrc_s) state_d = ST_LEFT;
          ST_LEFT:  if (lrc_s)  state_d = ST_RIGHT;
          ST_RIGHT: if (!lrc_s) state_d = ST_LEFT;
          default:              state_d = ST_IDLE;
        endcase
      end
      if (word_done) begin
        if (state_q == ST_LEFT) begin
          hold_l_d = word_aligned;
        end else begin
          pair_vld_p1_d = 1'b1;
          pair_l_p1_d   = hold_l_q;
          pair_r_p1_d   = word_aligned;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sr_q          <= '0;
      hold_l_q      <= '0;
      pair_vld_p1_q <= 1'b0;
      pair_l_p1_q   <= '0;
      pair_r_p1_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      hold_l_q      <= hold_l_d;
      pair_vld_p1_q <= pair_vld_p1_d;
      pair_l_p1_q   <= pair_l_p1_d;
      pair_r_p1_q   <= pair_r_p1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1 -> p2: output pair register, handshake and overflow
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sample_l_q, sample_l_d;
  logic [DATA_WIDTH-1:0] sample_r_q, sample_r_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d, ovf_set;
  logic                  load;

  always_comb begin
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    ovf_set    = 1'b0;
    load       = 1'b0;
    if (valid_q && sample_ready) valid_d = 1'b0;
    if (pair_vld_p1_q) begin
      // A pair still waiting for the consumer is never overwritten.
      if (valid_q && !sample_ready) begin
        ovf_set = 1'b1;
      end else begin
        load       = 1'b1;
        sample_l_d = pair_l_p1_q;
        sample_r_d = pair_r_p1_q;
        valid_d    = 1'b1;
      end
    end
    if (overflow_clr) ovf_d = 1'b0;
    if (ovf_set)      ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign overflow     = ovf_q;

`ifdef I2S_RX_PEAK_METER_EN
  // Magnitude of a two's-complement sample; the most negative code has no
  // positive counterpart in DATA_WIDTH-1 bits and saturates to all ones.
  function automatic logic [DATA_WIDTH-2:0] abs_sat(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] neg;
    neg = ~s + 1'b1;
    if (s[DATA_WIDTH-1] && (s[DATA_WIDTH-2:0] == '0)) return '1;
    return s[DATA_WIDTH-1] ? neg[DATA_WIDTH-2:0] : s[DATA_WIDTH-2:0];
  endfunction

  logic [DATA_WIDTH-2:0] peak_l_q, peak_l_d, mag_l;
  logic [DATA_WIDTH-2:0] peak_r_q, peak_r_d, mag_r;

  assign mag_l = abs_sat(pair_l_p1_q);
  assign mag_r = abs_sat(pair_r_p1_q);

  // A loaded pair takes priority over a simultaneous clear.
  always_comb begin
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (peak_clr) begin
      peak_l_d = '0;
      peak_r_d = '0;
    end
    if (load) begin
      peak_l_d = (mag_l > peak_l_q) ? mag_l : peak_l_q;
      peak_r_d = (mag_r > peak_r_q) ? mag_r : peak_r_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_l = peak_l_q;
  assign peak_r = peak_r_q;
`else
  logic unused_peak;
  assign unused_peak = peak_clr ^ load;
  assign peak_l      = '0;
  assign peak_r      = '0;
`endif

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 24, SHALL set captured sample width per channel, range 8..32.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set synchroniser depth on AC inputs, range 2..3.
REQ-003 Port CLK, input, 1: the single block clock; AC_BCLK frequency SHALL be at most CLK/4.
REQ-004 Port RESET, input, 1: asynchronous, active-high reset.
REQ-005 Port AC_BCLK, input, 1: codec bit clock, asynchronous to CLK.
REQ-006 Port AC_RECLRC, input, 1: record word select; low = left, high = right.
REQ-007 Port AC_RECDAT, input, 1: record serial data, MSB first.
REQ-008 Port sample_l, output, DATA_WIDTH: left sample of the current pair.
REQ-009 Port sample_r, output, DATA_WIDTH: right sample of the current pair.
REQ-010 Port sample_valid, output, 1: pair on sample_l/sample_r is valid.
REQ-011 Port sample_ready, input, 1: consumer accepts the pair when high with sample_valid.
REQ-012 Port overflow, output, 1: sticky flag for a dropped pair.
REQ-013 Port overflow_clr, input, 1: clears overflow.
REQ-014 Port peak_l, output, DATA_WIDTH-1: left absolute peak.
REQ-015 Port peak_r, output, DATA_WIDTH-1: right absolute peak.
REQ-016 Port peak_clr, input, 1: clears both peaks.

Function
REQ-017 AC_BCLK, AC_RECLRC and AC_RECDAT SHALL each pass through SYNC_STAGES flops; a BCLK rise SHALL be a 0->1 transition of synchronised BCLK.
REQ-018 On each BCLK rise, the block SHALL sample LRC and DAT; an LRC value differing from the previous rise SHALL mark a word boundary.
REQ-019 Per I2S timing, the MSB SHALL be the DAT bit sampled on the rise after the boundary rise.
REQ-020 FSM states: IDLE, LEFT, RIGHT; IDLE->LEFT on a boundary with LRC=0; LEFT->RIGHT on a boundary with LRC=1; RIGHT->LEFT on a boundary with LRC=0; IDLE ignores every boundary with LRC=1.
REQ-021 The bit counter SHALL reset on each boundary and stop at DATA_WIDTH; bits beyond DATA_WIDTH SHALL be discarded.
REQ-022 A word shorter than DATA_WIDTH (boundary at count 1..DATA_WIDTH-1) SHALL complete MSB-aligned, with the remaining LSBs set to zero.
REQ-023 The left word SHALL complete into a hold register; the pair SHALL commit when the right word completes.
REQ-024 sample_valid SHALL rise SYNC_STAGES+2 CLK cycles after the AC_BCLK rise carrying the right LSB.
REQ-025 sample_l, sample_r and sample_valid SHALL remain stable while sample_valid=1 and sample_ready=0.
REQ-026 A commit while sample_valid=1 and sample_ready=0 SHALL drop the new pair, leave the outputs unchanged, and set overflow.
REQ-027 A commit in the same cycle as sample_valid=1 and sample_ready=1 SHALL load the new pair, keeping sample_valid=1 with no overflow.
REQ-028 If overflow is set and cleared in the same cycle, set SHALL win.

Reset
REQ-029 RESET SHALL asynchronously force: FSM IDLE, counter 0, synchronisers 0, sample_l/sample_r 0, sample_valid 0, overflow 0, peaks 0.
REQ-030 After RESET deasserts, no pair SHALL commit until a full left word following an LRC 1->0 boundary has been received; a partial frame in progress at reset SHALL be discarded.

Configuration
REQ-031 With macro I2S_RX_PEAK_METER_EN defined, each committed sample SHALL update its peak to max(peak, |sample|); the most negative value SHALL saturate to all-ones; peak_clr SHALL zero both peaks, and a commit in the same cycle SHALL win.
REQ-032 Without I2S_RX_PEAK_METER_EN, peak_l and peak_r SHALL be tied to 0, peak_clr SHALL be ignored, and no meter logic SHALL be synthesised.

Structure
REQ-033 Package i2s_pkg SHALL hold the FSM state typedef, the DATA_WIDTH default constant and the SYNC_STAGES default constant.
REQ-034 Synchronisation SHALL be a sub-module i2s_sync, instantiated once per AC input.

Verification
REQ-035 DATA_WIDTH=24, left 0xA5A5A5, right 0x5A5A5A, sample_ready=1 -> one pulse with sample_l=0xA5A5A5 and sample_r=0x5A5A5A; overflow=0.
REQ-036 sample_ready=0 over two frames -> the first pair is held, the second pair is dropped, overflow=1; one overflow_clr pulse -> overflow=0.
REQ-037 16-bit frames, left 0xBEEF -> sample_l=0xBEEF00; 32-bit frames, left 0x12345678 -> sample_l=0x123456.
REQ-038 RESET pulsed mid-left-word, then a full frame sent -> no pair from the partial frame; the next full frame is output correctly.
REQ-039 With I2S_RX_PEAK_METER_EN: left 0xF00000, then 0x080000 -> peak_l=0x100000; peak_clr -> 0; left 0x800000 -> peak_l=0x7FFFFF.
